// File: rtl/uart_rx_fsm.sv
// UART receiver: 2-flop synchronized line, start/data/stop framing FSM,
// single-entry output register with valid/ready handshake and error pulses.
module uart_rx_fsm #(
    parameter int unsigned F_SIZE       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_SIZE     = $clog2(CLKS_PER_BIT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              rx_ready,
    output logic [F_SIZE-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned IDX_SIZE = $clog2(F_SIZE) + 1;
    localparam logic [CNT_SIZE-1:0] HALF_LAST = CNT_SIZE'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_SIZE-1:0] BIT_LAST  = CNT_SIZE'(CLKS_PER_BIT - 1);
    localparam logic [IDX_SIZE-1:0] IDX_LAST  = IDX_SIZE'(F_SIZE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_q, state_d;
    logic [CNT_SIZE-1:0] cnt_q, cnt_d;
    logic [IDX_SIZE-1:0] idx_q, idx_d;
    logic [F_SIZE-1:0]   shift_q, shift_d;
    logic [F_SIZE-1:0]   data_d;
    logic                valid_d, ferr_d, ovr_d, busy_d;
    logic                word_done;
    logic                rx_meta, rx_s, rx_prev;
    logic                start_edge;

    // Synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign start_edge = rx_prev & ~rx_s;

    // Framing FSM: next state, counters and shift register
    always_comb begin
        state_d   = state_q;
        cnt_d     = CNT_SIZE'(cnt_q + 1'b1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        word_done = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_edge) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[F_SIZE-1:1]};
                    idx_d   = IDX_SIZE'(idx_q + 1'b1);
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    state_d   = IDLE;
                    word_done = rx_s;
                    ferr_d    = ~rx_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: accept clears, a completed word loads unless it would overwrite
    always_comb begin
        data_d  = rx_data;
        valid_d = rx_valid;
        ovr_d   = 1'b0;
        busy_d  = (state_d != IDLE);
        if (rx_valid && rx_ready) begin
            valid_d = 1'b0;
        end
        if (word_done) begin
            if (rx_valid && !rx_ready) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            rx_data   <= data_d;
            rx_valid  <= valid_d;
            frame_err <= ferr_d;
            overrun   <= ovr_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm (F_SIZE=8, CLKS_PER_BIT=16) with a
// negedge monitor feeding a word scoreboard and pulse counters.
module tb_uart_rx_fsm;

    localparam int unsigned F_SIZE  = 8;
    localparam int unsigned CPB     = 16;
    // 2 sync flops + edge flop, half bit of start, F_SIZE data bits, stop bit
    localparam int LATENCY = 3 + CPB / 2 + CPB * F_SIZE + CPB;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx;
    logic              rx_ready;
    logic [F_SIZE-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    uart_rx_fsm #(.F_SIZE(F_SIZE), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ferr_cnt = 0, ferr_long = 0, ovr_cnt = 0, ovr_long = 0;
    int vrise_cnt = 0, vrise_cyc = 0, busy_cnt = 0, unstable = 0, reaccept = 0;
    logic ferr_p = 1'b0, ovr_p = 1'b0, v_p = 1'b0, rdy_p = 1'b0;
    logic [F_SIZE-1:0] data_p = '0;
    logic [F_SIZE-1:0] got_q[$];
    logic [F_SIZE-1:0] exp_q[$];

    // Monitor: inputs change just after posedge, so negedge values are what the next edge sees
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) begin
                if (ferr_p) ferr_long++; else ferr_cnt++;
            end
            if (overrun) begin
                if (ovr_p) ovr_long++; else ovr_cnt++;
            end
            if (rx_valid && !v_p) begin
                vrise_cnt++;
                vrise_cyc = cyc;
            end
            if (rx_valid && v_p && rdy_p) reaccept++;
            if (rx_valid && v_p && !rdy_p && rx_data !== data_p) unstable++;
            if (busy) busy_cnt++;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
        end
        ferr_p = frame_err;
        ovr_p  = overrun;
        v_p    = rx_valid;
        rdy_p  = rx_ready;
        data_p = rx_data;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [F_SIZE-1:0] d, input logic stop);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < int'(F_SIZE); i++) begin
            rx = d[i];
            repeat (CPB) tick();
        end
        rx = stop;
        repeat (CPB) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
        repeat (3) tick();
        total++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rx_valid); else passed++;
        total++; if (rx_data !== '0) $display("FAIL reset_data: got %02h expected 00", rx_data); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", frame_err); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_ovr: got %b expected 0", overrun); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        rst = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_single();
        int v0, c0, n;
        logic [F_SIZE-1:0] e, g;
        rx_ready = 1'b0;
        exp_q.push_back(8'hA5);
        v0 = vrise_cnt;
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        n = 0;
        while (!rx_valid && n < 50) begin tick(); n++; end
        total++; if (rx_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", rx_valid); else passed++;
        total++; if (vrise_cnt - v0 != 1 || vrise_cyc - c0 != LATENCY)
            $display("FAIL single_latency: got %0d cycles (%0d rises) expected %0d (1 rise)", vrise_cyc - c0, vrise_cnt - v0, LATENCY);
            else passed++;
        total++; if (rx_data !== 8'hA5) $display("FAIL single_data: got %02h expected a5", rx_data); else passed++;
        repeat (20) tick();
        total++; if (rx_valid !== 1'b1) $display("FAIL single_hold: got %b expected 1", rx_valid); else passed++;
        total++; if (unstable != 0) $display("FAIL single_stable: got %0d changes expected 0", unstable); else passed++;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
        total++; if (rx_valid !== 1'b0) $display("FAIL single_clear: got %b expected 0", rx_valid); else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) $display("FAIL single_sb: got none expected %02h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL single_sb: got %02h expected %02h", g, e); else passed++;
            end
        end
    endtask

    task automatic test_glitch();
        int b0, v0, f0;
        b0 = busy_cnt; v0 = vrise_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (30) tick();
        total++; if (busy_cnt - b0 != int'(CPB / 2)) $display("FAIL glitch_busy_cycles: got %0d expected %0d", busy_cnt - b0, CPB / 2); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL glitch_busy: got %b expected 0", busy); else passed++;
        total++; if (vrise_cnt != v0) $display("FAIL glitch_valid: got %0d rises expected 0", vrise_cnt - v0); else passed++;
        total++; if (ferr_cnt != f0) $display("FAIL glitch_ferr: got %0d pulses expected 0", ferr_cnt - f0); else passed++;
    endtask

    task automatic test_frame_err();
        int b0, v0, f0;
        v0 = vrise_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        b0 = busy_cnt;
        repeat (40) tick();
        total++; if (ferr_cnt - f0 != 1) $display("FAIL ferr_pulse: got %0d pulses expected 1", ferr_cnt - f0); else passed++;
        total++; if (vrise_cnt != v0 || rx_valid !== 1'b0) $display("FAIL ferr_valid: got %0d rises valid=%b expected 0", vrise_cnt - v0, rx_valid); else passed++;
        total++; if (busy_cnt != b0) $display("FAIL ferr_retrigger: got %0d busy cycles expected 0", busy_cnt - b0); else passed++;
        rx = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_overrun();
        int o0;
        logic [F_SIZE-1:0] e, g;
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) tick();
        total++; if (ovr_cnt - o0 != 1) $display("FAIL ovr_pulse: got %0d pulses expected 1", ovr_cnt - o0); else passed++;
        total++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", rx_valid); else passed++;
        total++; if (rx_data !== 8'h11) $display("FAIL ovr_data: got %02h expected 11", rx_data); else passed++;
        total++; if (unstable != 0) $display("FAIL ovr_stable: got %0d changes expected 0", unstable); else passed++;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
        total++; if (rx_valid !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", rx_valid); else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) $display("FAIL ovr_sb: got none expected %02h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL ovr_sb: got %02h expected %02h", g, e); else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int v0, o0, r0;
        logic [F_SIZE-1:0] e, g;
        rx_ready = 1'b1;
        v0 = vrise_cnt; o0 = ovr_cnt; r0 = reaccept;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (4) tick();
        rx_ready = 1'b0;
        tick();
        total++; if (vrise_cnt - v0 != 2) $display("FAIL b2b_pulses: got %0d rises expected 2", vrise_cnt - v0); else passed++;
        total++; if (reaccept != r0) $display("FAIL b2b_width: got %0d long pulses expected 0", reaccept - r0); else passed++;
        total++; if (ovr_cnt != o0) $display("FAIL b2b_ovr: got %0d pulses expected 0", ovr_cnt - o0); else passed++;
        total++; if (rx_valid !== 1'b0) $display("FAIL b2b_idle_valid: got %b expected 0", rx_valid); else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) $display("FAIL b2b_sb: got none expected %02h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL b2b_sb: got %02h expected %02h", g, e); else passed++;
            end
        end
        total++; if (got_q.size() != 0) $display("FAIL b2b_extra: got %0d extra words expected 0", got_q.size()); else passed++;
    endtask

    task automatic test_reset_midframe();
        int b0, v0, f0;
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1);
        tick();
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) $display("FAIL rstmid_pre: got valid=%b data=%02h expected 1/5a", rx_valid, rx_data); else passed++;
        b0 = 0;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (CPB + 4 * CPB + CPB / 2) tick();
                rst = 1'b1;
                #1;
                total++; if (rx_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", rx_valid); else passed++;
                total++; if (rx_data !== '0) $display("FAIL rstmid_data: got %02h expected 00", rx_data); else passed++;
                total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else passed++;
                total++; if (frame_err !== 1'b0 || overrun !== 1'b0) $display("FAIL rstmid_flags: got ferr=%b ovr=%b expected 0/0", frame_err, overrun); else passed++;
                repeat (2) tick();
                rst = 1'b0;
                b0 = busy_cnt;
                v0 = vrise_cnt;
                f0 = ferr_cnt;
            end
        join
        repeat (40) tick();
        total++; if (busy_cnt != b0) $display("FAIL rstmid_restart: got %0d busy cycles expected 0", busy_cnt - b0); else passed++;
        total++; if (vrise_cnt != v0 || rx_valid !== 1'b0) $display("FAIL rstmid_word: got %0d rises valid=%b expected 0", vrise_cnt - v0, rx_valid); else passed++;
        total++; if (ferr_cnt != f0) $display("FAIL rstmid_ferr: got %0d pulses expected 0", ferr_cnt - f0); else passed++;
    endtask

    task automatic test_pulse_widths();
        total++; if (ferr_long != 0) $display("FAIL ferr_width: got %0d extra cycles expected 0", ferr_long); else passed++;
        total++; if (ovr_long != 0) $display("FAIL ovr_width: got %0d extra cycles expected 0", ovr_long); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        test_pulse_widths();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 SHALL have parameter F_SIZE, default 8, data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per bit period; legal range >= 4.
REQ-003 SHALL have parameter CNT_SIZE, default $clog2(CLKS_PER_BIT), width of the bit-period counter.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-008 SHALL have port rx_data  output  F_SIZE  received word, LSB = first data bit.
REQ-009 SHALL have port rx_valid  output  1  rx_data holds an unconsumed word.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse, completed word dropped.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1; all logic uses the synchronized value rx_s.
REQ-014 SHALL detect a start edge as rx_s previous=1, current=0; a line held low never retriggers.
REQ-015 SHALL implement states IDLE, START, DATA, STOP.
REQ-016 IDLE: on start edge -> START, counter cleared; otherwise stay.
REQ-017 START: sample rx_s when counter = CLKS_PER_BIT/2-1; if 1 (glitch) -> IDLE, no flags; if 0 -> DATA, counter cleared.
REQ-018 DATA: sample rx_s when counter = CLKS_PER_BIT-1; shift in LSB first; counter wraps to 0; after F_SIZE samples -> STOP.
REQ-019 DATA bit index SHALL be $clog2(F_SIZE)+1 bits wide and clear on every entry to DATA.
REQ-020 STOP: sample at counter = CLKS_PER_BIT-1, then -> IDLE unconditionally.
REQ-021 STOP sample 1: word delivered per REQ-023..025; STOP sample 0: frame_err pulses the following cycle, word discarded, rx_data/rx_valid unchanged.
REQ-022 Latency: rx_valid rises the cycle after the stop-bit sample edge.
REQ-023 rx_valid SHALL hold, with rx_data stable, until a cycle with rx_valid=1 and rx_ready=1; it clears after that edge.
REQ-024 Word completion while rx_valid=1 and rx_ready=0: new word dropped, old retained, overrun pulses one cycle.
REQ-025 Word completion in the same cycle as an accept: new word loaded, rx_valid stays 1, no overrun.
REQ-026 rx_ready while rx_valid=0 SHALL have no effect.
REQ-027 frame_err and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-028 On rst: state IDLE, counters 0, shift register 0, rx_data 0, rx_valid 0, frame_err 0, overrun 0, busy 0, synchronizer flops 1.
REQ-029 rst asserted mid-frame SHALL abandon the frame with no flag or partial word; after release a new start edge is required.

Verification (F_SIZE=8, CLKS_PER_BIT=16)
REQ-030 Frame 0xA5 with a valid stop bit, rx_ready=0 -> rx_valid=1, rx_data=8'hA5 held until rx_ready pulse, then rx_valid=0.
REQ-031 rx low for 3 cycles, then high -> returns to IDLE, busy drops, rx_valid/frame_err stay 0.
REQ-032 Frame 0x3C with stop bit 0 -> frame_err one-cycle pulse, rx_valid stays 0; rx held low afterwards, no retrigger until rx high then low.
REQ-033 Two frames 0x11 then 0x22, rx_ready=0 -> rx_data=8'h11, one overrun pulse at second completion.
REQ-034 Back-to-back frames 0x01, 0xFF, rx_ready=1 constantly -> two single-cycle rx_valid pulses with data 8'h01 then 8'hFF, no overrun.
REQ-035 rst asserted during data bit 4 of a frame -> all outputs per REQ-028 immediately; remaining line activity until next idle-to-low edge produces no output.
